jtkunio_dwnld: RTL and testbench
================================

JTKUNIO_DWNLD -- requirements
Module: jtkunio_dwnld

Interface
REQ-001 SHALL have parameter BA1_START, default 25'h10000: first byte of the sound/PCM ROM region (SDRAM bank 1).
REQ-002 SHALL have parameter BA2_START, default 25'h38000: first byte of the char/scroll ROM region (bank 2).
REQ-003 SHALL have parameter BA3_START, default 25'h58000: first byte of the object ROM region (bank 3).
REQ-004 SHALL have parameter PROM_START, default 25'h98000: first byte of the MCU PROM region (512 bytes).
REQ-005 SHALL have port clk, input, 1 bit: single clock; all logic runs on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port downloading, input, 1 bit: a ROM download is in progress.
REQ-008 SHALL have ports ioctl_addr (input, 25 bits), ioctl_dout (input, 8 bits) and ioctl_wr (input, 1 bit): the byte stream from the loader.
REQ-009 SHALL have ports prog_addr (output, 22 bits) and prog_data (output, 16 bits): SDRAM word address and write data.
REQ-010 SHALL have ports prog_mask (output, 2 bits, active-low byte enables), prog_ba (output, 2 bits, SDRAM bank) and prog_we (output, 1 bit, write request).
REQ-011 SHALL have ports prog_ack (input, 1 bit) and prog_rdy (input, 1 bit): SDRAM accepted the request / write completed.
REQ-012 SHALL have ports prom_we (output, 1 bit: one-cycle PROM write strobe) and dwnld_busy (output, 1 bit).
REQ-013 SHALL have port overflow (output, 1 bit): sticky flag, set when a byte is lost.

Function
REQ-014 Region decode SHALL compare ioctl_addr against the parameters:
- below BA1_START: bank 0
- below BA2_START: bank 1
- below BA3_START: bank 2
- below PROM_START: bank 3
- otherwise: PROM
REQ-015 Offset SHALL be ioctl_addr minus the selected region start; prog_addr = offset[22:1], zero-extended to 22 bits.
REQ-016 For SDRAM regions:
- prog_data = {ioctl_dout, ioctl_dout}
- prog_mask = 2'b10 for even offset (low byte), 2'b01 for odd offset (high byte).
REQ-017 For the PROM region:
- prog_addr[8:0] = offset[8:0] and prog_data[7:0] = ioctl_dout
- prom_we pulses high for exactly one cycle, one cycle after ioctl_wr
- prog_we stays low
- the FSM stays in IDLE.
REQ-018 PROM offsets of 512 and above SHALL be discarded silently.
REQ-019 The FSM SHALL have states IDLE, REQ and WAIT.
REQ-020 IDLE to REQ: on ioctl_wr to an SDRAM region (or a pending held byte); the address, data, mask and bank are registered and prog_we is set on the next edge.
REQ-021 REQ to WAIT: on prog_ack, with prog_we cleared on the same edge.
REQ-022 WAIT to IDLE: on prog_rdy.
REQ-023 One-entry hold buffer: an ioctl_wr arriving in REQ or WAIT SHALL be held and issued on the cycle after returning to IDLE.
REQ-024 A second ioctl_wr while the hold buffer is full SHALL be dropped and SHALL set overflow; overflow clears only on reset or on a downloading rising edge.
REQ-025 prog_ack and prog_rdy arriving in the same cycle while in REQ SHALL go directly to IDLE.
REQ-026 prog_rdy seen in IDLE or REQ without a prior ack SHALL be ignored.
REQ-027 ioctl_wr SHALL be ignored while downloading is low.
REQ-028 dwnld_busy SHALL be high while downloading is high, the FSM is not IDLE, or the hold buffer is full, and for 16 further cycles after all of these clear (4-bit countdown).
REQ-029 If downloading falls mid-transaction, the transaction and any held byte SHALL complete normally.

Reset
REQ-030 Asserting rst_n low SHALL asynchronously set: FSM to IDLE, prog_we=0, prom_we=0, prog_addr=0, prog_data=0, prog_mask=2'b11, prog_ba=0, hold buffer empty, overflow=0, busy counter=0, dwnld_busy=0.
REQ-031 Reset mid-transaction SHALL abandon it with no further prog_we.

Configuration
REQ-032 JTKUNIO_GFXSWAP_EN defined: for banks 2 and 3, the word address SHALL be reordered so that the four byte planes of a 32-bit graphics word are adjacent: prog_addr = {offset[22:19], offset[16:1], offset[18:17]}; ROM files load unmodified.
REQ-033 JTKUNIO_GFXSWAP_EN undefined: all banks SHALL use the linear mapping of REQ-015.

Structure
REQ-034 Package jtkunio_pkg SHALL hold:
- the FSM state enum
- the default region start constants
- the PROM size constant (512).
REQ-035 The region decoder (address to bank, offset, is_prom) SHALL be the single sub-module jtkunio_dwnld_dec, purely combinational.

Verification
REQ-036 Main byte: downloading=1, ioctl_wr at address 0x00003 with data 0x5A -> prog_ba=0, prog_addr=1, prog_mask=2'b01, prog_data=16'h5A5A, prog_we until ack.
REQ-037 Bank boundaries: address 0x0FFFF -> bank 0, word 0x7FFF; address 0x10000 -> bank 1, word 0.
REQ-038 PROM: address 0x98105 with data 0xC3 -> prom_we one cycle, prog_addr[8:0]=0x105, no prog_we; address 0x98200 -> nothing.
REQ-039 Back-to-back: three ioctl_wr one cycle apart, ack delayed 5 cycles -> bytes 1 and 2 written in order, byte 3 dropped, overflow=1.
REQ-040 Tail: downloading falls in WAIT, prog_rdy 3 cycles later -> dwnld_busy stays high for 16 cycles after IDLE, then falls.
REQ-041 Reset: rst_n low during REQ -> prog_we=0 immediately, outputs at reset values.

Source files
------------

// File: rtl/jtkunio_pkg.sv
// Shared types and constants for the Kunio ROM downloader: FSM states,
// default region start addresses and the MCU PROM size.
package jtkunio_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  localparam logic [24:0] BA1_START_DEF  = 25'h10000;
  localparam logic [24:0] BA2_START_DEF  = 25'h38000;
  localparam logic [24:0] BA3_START_DEF  = 25'h58000;
  localparam logic [24:0] PROM_START_DEF = 25'h98000;
  localparam int          PROM_SIZE      = 512;

endpackage

// File: rtl/jtkunio_dwnld_dec.sv
// Region decoder: maps a loader byte address to an SDRAM bank or the MCU PROM,
// plus the byte offset inside the selected region. Purely combinational.
module jtkunio_dwnld_dec
  import jtkunio_pkg::*;
#(
  parameter logic [24:0] BA1_START  = BA1_START_DEF,
  parameter logic [24:0] BA2_START  = BA2_START_DEF,
  parameter logic [24:0] BA3_START  = BA3_START_DEF,
  parameter logic [24:0] PROM_START = PROM_START_DEF
) (
  input  logic [24:0] addr,
  output logic [1:0]  bank,
  output logic [24:0] offset,
  output logic        is_prom
);

  logic [24:0] start;

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    bank    = 2'd0;
    start   = 25'd0;
    is_prom = 1'b0;
    if (addr < BA1_START) begin
      bank  = 2'd0;
      start = 25'd0;
    end else if (addr < BA2_START) begin
      bank  = 2'd1;
      start = BA1_START;
    end else if (addr < BA3_START) begin
      bank  = 2'd2;
      start = BA2_START;
    end else if (addr < PROM_START) begin
      bank  = 2'd3;
      start = BA3_START;
    end else begin
      is_prom = 1'b1;
      start   = PROM_START;
    end
    offset = addr - start;
  end

endmodule

// File: rtl/jtkunio_dwnld.sv
// Kunio ROM downloader: turns the loader byte stream into SDRAM word writes
// with a one-entry hold buffer, plus MCU PROM strobes. Optional macro
// JTKUNIO_GFXSWAP_EN reorders graphics word addresses for banks 2 and 3.
module jtkunio_dwnld
  import jtkunio_pkg::*;
#(
  parameter logic [24:0] BA1_START  = BA1_START_DEF,
  parameter logic [24:0] BA2_START  = BA2_START_DEF,
  parameter logic [24:0] BA3_START  = BA3_START_DEF,
  parameter logic [24:0] PROM_START = PROM_START_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        downloading,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic        ioctl_wr,
  output logic [21:0] prog_addr,
  output logic [15:0] prog_data,
  output logic [1:0]  prog_mask,
  output logic [1:0]  prog_ba,
  output logic        prog_we,
  input  logic        prog_ack,
  input  logic        prog_rdy,
  output logic        prom_we,
  output logic        dwnld_busy,
  output logic        overflow
);

  state_t      state_q, state_d;
  logic        prog_we_q, prog_we_d, prom_we_q, prom_we_d;
  logic [21:0] prog_addr_q, prog_addr_d;
  logic [15:0] prog_data_q, prog_data_d;
  logic [1:0]  prog_mask_q, prog_mask_d, prog_ba_q, prog_ba_d;
  logic        hold_full_q, hold_full_d;
  logic [24:0] hold_addr_q, hold_addr_d;
  logic [7:0]  hold_data_q, hold_data_d;
  logic        overflow_q, overflow_d, downloading_q;
  logic [3:0]  busy_cnt_q, busy_cnt_d;
  logic        dwnld_busy_q, dwnld_busy_d;

  logic        use_hold, wr_v, dl_rise, active, prom_ok;
  logic [24:0] src_addr, dec_offset;
  logic [7:0]  src_data;
  logic [1:0]  dec_bank;
  logic        dec_is_prom;
  logic [21:0] word_addr;

  // A held byte takes priority over the live stream once the FSM is idle.
  assign use_hold = (state_q == IDLE) && hold_full_q;
  assign src_addr = use_hold ? hold_addr_q : ioctl_addr;
  assign src_data = use_hold ? hold_data_q : ioctl_dout;
  assign wr_v     = downloading & ioctl_wr;
  assign dl_rise  = downloading & ~downloading_q;
  assign active   = downloading | (state_q != IDLE) | hold_full_q;
  assign prom_ok  = dec_offset < 25'(PROM_SIZE);

  jtkunio_dwnld_dec #(
    .BA1_START (BA1_START),
    .BA2_START (BA2_START),
    .BA3_START (BA3_START),
    .PROM_START(PROM_START)
  ) u_dec (
    .addr   (src_addr),
    .bank   (dec_bank),
    .offset (dec_offset),
    .is_prom(dec_is_prom)
  );

`ifdef JTKUNIO_GFXSWAP_EN
  // Puts the four byte planes of one 32-bit graphics word at adjacent addresses.
  assign word_addr = dec_bank[1] ?
                     {dec_offset[22:19], dec_offset[16:1], dec_offset[18:17]} :
                     dec_offset[22:1];
`else
  assign word_addr = dec_offset[22:1];
`endif

  always_comb begin
    state_d      = state_q;
    prog_we_d    = prog_we_q;
    prom_we_d    = 1'b0;
    prog_addr_d  = prog_addr_q;
    prog_data_d  = prog_data_q;
    prog_mask_d  = prog_mask_q;
    prog_ba_d    = prog_ba_q;
    hold_full_d  = hold_full_q;
    hold_addr_d  = hold_addr_q;
    hold_data_d  = hold_data_q;
    overflow_d   = overflow_q & ~dl_rise;

    case (state_q)
      IDLE: begin
        if (hold_full_q || wr_v) begin
          // Draining the hold buffer while a new byte arrives refills it.
          hold_full_d = hold_full_q & wr_v;
          if (hold_full_q && wr_v) begin
            hold_addr_d = ioctl_addr;
            hold_data_d = ioctl_dout;
          end
          if (dec_is_prom) begin
            if (prom_ok) begin
              prom_we_d   = 1'b1;
              prog_addr_d = {13'd0, dec_offset[8:0]};
              prog_data_d = {8'h00, src_data};
            end
          end else begin
            prog_addr_d = word_addr;
            prog_data_d = {src_data, src_data};
            prog_mask_d = dec_offset[0] ? 2'b01 : 2'b10;
            prog_ba_d   = dec_bank;
            prog_we_d   = 1'b1;
            state_d     = REQ;
          end
        end
      end
      REQ: begin
        if (prog_ack) begin
          prog_we_d = 1'b0;
          state_d   = prog_rdy ? IDLE : WAIT;
        end
      end
      WAIT: begin
        if (prog_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (state_q != IDLE && wr_v) begin
      if (hold_full_q) begin
        overflow_d = 1'b1;
      end else begin
        hold_full_d = 1'b1;
        hold_addr_d = ioctl_addr;
        hold_data_d = ioctl_dout;
      end
    end

    busy_cnt_d   = active ? 4'hf : (busy_cnt_q != 4'd0 ? busy_cnt_q - 4'd1 : 4'd0);
    dwnld_busy_d = active | (busy_cnt_q != 4'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      prog_we_q     <= 1'b0;
      prom_we_q     <= 1'b0;
      prog_addr_q   <= '0;
      prog_data_q   <= '0;
      prog_mask_q   <= 2'b11;
      prog_ba_q     <= '0;
      hold_full_q   <= 1'b0;
      hold_addr_q   <= '0;
      hold_data_q   <= '0;
      overflow_q    <= 1'b0;
      downloading_q <= 1'b0;
      busy_cnt_q    <= '0;
      dwnld_busy_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q       <= state_d;
      prog_we_q     <= prog_we_d;
      prom_we_q     <= prom_we_d;
      prog_addr_q   <= prog_addr_d;
      prog_data_q   <= prog_data_d;
      prog_mask_q   <= prog_mask_d;
      prog_ba_q     <= prog_ba_d;
      hold_full_q   <= hold_full_d;
      hold_addr_q   <= hold_addr_d;
      hold_data_q   <= hold_data_d;
      overflow_q    <= overflow_d;
      downloading_q <= downloading;
      busy_cnt_q    <= busy_cnt_d;
      dwnld_busy_q  <= dwnld_busy_d;
    end
  end

  assign prog_addr  = prog_addr_q;
  assign prog_data  = prog_data_q;
  assign prog_mask  = prog_mask_q;
  assign prog_ba    = prog_ba_q;
  assign prog_we    = prog_we_q;
  assign prom_we    = prom_we_q;
  assign dwnld_busy = dwnld_busy_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_jtkunio_dwnld.sv
// Directed self-checking bench for jtkunio_dwnld: byte writes, region bounds,
// PROM strobes, hold buffer overflow, busy tail and mid-transaction reset.
module tb_jtkunio_dwnld;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        downloading = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic        ioctl_wr = 1'b0;
  logic [21:0] prog_addr;
  logic [15:0] prog_data;
  logic [1:0]  prog_mask, prog_ba;
  logic        prog_we, prog_ack = 1'b0, prog_rdy = 1'b0;
  logic        prom_we, dwnld_busy, overflow;

  int errors = 0;
  int checks = 0;

  jtkunio_dwnld dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .downloading(downloading),
    .ioctl_addr (ioctl_addr),
    .ioctl_dout (ioctl_dout),
    .ioctl_wr   (ioctl_wr),
    .prog_addr  (prog_addr),
    .prog_data  (prog_data),
    .prog_mask  (prog_mask),
    .prog_ba    (prog_ba),
    .prog_we    (prog_we),
    .prog_ack   (prog_ack),
    .prog_rdy   (prog_rdy),
    .prom_we    (prom_we),
    .dwnld_busy (dwnld_busy),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [24:0] a, input logic [7:0] d);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    tick();
    ioctl_wr   = 1'b0;
  endtask

  task automatic ack_then_rdy();
    prog_ack = 1'b1;
    tick();
    prog_ack = 1'b0;
    prog_rdy = 1'b1;
    tick();
    prog_rdy = 1'b0;
  endtask

  initial begin
    logic [21:0] gfx_exp;

    // Reset values
    #12;
    check("rst_we",   32'(prog_we),    32'd0);
    check("rst_mask", 32'(prog_mask),  32'd3);
    check("rst_addr", 32'(prog_addr),  32'd0);
    check("rst_prom", 32'(prom_we),    32'd0);
    check("rst_busy", 32'(dwnld_busy), 32'd0);
    check("rst_ovf",  32'(overflow),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Main byte at 0x00003
    downloading = 1'b1;
    tick();
    send_byte(25'h00003, 8'h5A);
    check("main_we",   32'(prog_we),   32'd1);
    check("main_ba",   32'(prog_ba),   32'd0);
    check("main_addr", 32'(prog_addr), 32'd1);
    check("main_mask", 32'(prog_mask), 32'd1);
    check("main_data", 32'(prog_data), 32'h5A5A);
    check("main_busy", 32'(dwnld_busy), 32'd1);
    tick(); tick();
    check("main_hold_we", 32'(prog_we), 32'd1);
    ack_then_rdy();
    check("main_we_off", 32'(prog_we), 32'd0);

    // Bank 0 upper edge, then ack and rdy together in REQ
    send_byte(25'h0FFFF, 8'h11);
    check("b0_ba",   32'(prog_ba),   32'd0);
    check("b0_addr", 32'(prog_addr), 32'h7FFF);
    check("b0_mask", 32'(prog_mask), 32'd1);
    prog_ack = 1'b1;
    prog_rdy = 1'b1;
    tick();
    prog_ack = 1'b0;
    prog_rdy = 1'b0;
    check("ackrdy_we", 32'(prog_we), 32'd0);

    // Bank 1 lower edge; must issue at once, so the FSM is back in IDLE
    send_byte(25'h10000, 8'h22);
    check("b1_we",   32'(prog_we),   32'd1);
    check("b1_ba",   32'(prog_ba),   32'd1);
    check("b1_addr", 32'(prog_addr), 32'd0);
    check("b1_mask", 32'(prog_mask), 32'd2);
    check("b1_data", 32'(prog_data), 32'h2222);
    prog_rdy = 1'b1;
    tick();
    prog_rdy = 1'b0;
    check("rdy_no_ack_we", 32'(prog_we), 32'd1);
    ack_then_rdy();

    // Bank 3 address with offset bit 17 set
    send_byte(25'h78004, 8'h33);
`ifdef JTKUNIO_GFXSWAP_EN
    gfx_exp = 22'h9;
`else
    gfx_exp = 22'h10002;
`endif
    check("b3_ba",   32'(prog_ba),   32'd3);
    check("b3_addr", 32'(prog_addr), 32'(gfx_exp));
    check("b3_mask", 32'(prog_mask), 32'd2);
    ack_then_rdy();

    // PROM write and out-of-range PROM byte
    send_byte(25'h98105, 8'hC3);
    check("prom_we",   32'(prom_we),         32'd1);
    check("prom_addr", 32'(prog_addr[8:0]),  32'h105);
    check("prom_data", 32'(prog_data[7:0]),  32'hC3);
    check("prom_no_prog", 32'(prog_we),      32'd0);
    tick();
    check("prom_pulse_end", 32'(prom_we), 32'd0);
    send_byte(25'h98200, 8'h44);
    check("prom_oob_we",   32'(prom_we), 32'd0);
    check("prom_oob_prog", 32'(prog_we), 32'd0);
    tick();
    check("prom_oob_we2", 32'(prom_we), 32'd0);

    // Three back-to-back bytes, ack delayed
    send_byte(25'h00020, 8'hA1);
    check("b2b_1_addr", 32'(prog_addr), 32'h10);
    check("b2b_1_data", 32'(prog_data), 32'hA1A1);
    send_byte(25'h00021, 8'hA2);
    send_byte(25'h00022, 8'hA3);
    check("b2b_ovf", 32'(overflow), 32'd1);
    tick(); tick(); tick();
    check("b2b_1_still", 32'(prog_data), 32'hA1A1);
    ack_then_rdy();
    check("b2b_gap_we", 32'(prog_we), 32'd0);
    tick();
    check("b2b_2_we",   32'(prog_we),   32'd1);
    check("b2b_2_addr", 32'(prog_addr), 32'h10);
    check("b2b_2_mask", 32'(prog_mask), 32'd1);
    check("b2b_2_data", 32'(prog_data), 32'hA2A2);
    ack_then_rdy();
    tick(); tick(); tick();
    check("b2b_3_dropped", 32'(prog_we), 32'd0);

    // Overflow clears on a new download start
    downloading = 1'b0;
    tick();
    check("ovf_sticky", 32'(overflow), 32'd1);
    downloading = 1'b1;
    tick();
    check("ovf_clear", 32'(overflow), 32'd0);

    // Busy tail: downloading falls in WAIT, rdy three cycles later
    send_byte(25'h00040, 8'h55);
    prog_ack = 1'b1;
    tick();
    prog_ack = 1'b0;
    downloading = 1'b0;
    tick(); tick(); tick();
    check("tail_busy_wait", 32'(dwnld_busy), 32'd1);
    prog_rdy = 1'b1;
    tick();
    prog_rdy = 1'b0;
    check("tail_busy_idle", 32'(dwnld_busy), 32'd1);
    for (int i = 0; i < 15; i++) tick();
    check("tail_busy_15", 32'(dwnld_busy), 32'd1);
    tick();
    check("tail_busy_16", 32'(dwnld_busy), 32'd0);

    // Writes ignored while downloading is low
    send_byte(25'h00050, 8'h66);
    check("nodl_we",   32'(prog_we),    32'd0);
    check("nodl_busy", 32'(dwnld_busy), 32'd0);

    // Asynchronous reset during REQ
    downloading = 1'b1;
    tick();
    send_byte(25'h00061, 8'h77);
    check("pre_rst_we", 32'(prog_we), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_we",   32'(prog_we),   32'd0);
    check("arst_mask", 32'(prog_mask), 32'd3);
    check("arst_addr", 32'(prog_addr), 32'd0);
    check("arst_data", 32'(prog_data), 32'd0);
    check("arst_busy", 32'(dwnld_busy), 32'd0);
    downloading = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick(); tick();
    check("post_rst_we", 32'(prog_we), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
